// File: rtl/reg_force_arbiter.sv
// Shared WIDTH-bit register that normally captures din every cycle.
// Requesters can take a time-limited, round-robin override lease that forces the register to their value.
module reg_force_arbiter #(
   parameter int WIDTH    = 8,
   parameter int NREQ     = 4,
   parameter int MAX_HOLD = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [WIDTH-1:0]       din,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ*WIDTH-1:0]  force_val,
   output logic [NREQ-1:0]        gnt,
   output logic [WIDTH-1:0]       q,
   output logic                   busy,
   output logic                   expired
);

   localparam int PW = $clog2(NREQ);
   localparam int CW = $clog2(MAX_HOLD + 1);

   typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

   state_t            state, state_nxt;
   logic [PW-1:0]     ptr, ptr_nxt;
   logic [PW-1:0]     sel, sel_nxt;
   logic [CW-1:0]     cnt, cnt_nxt;
   logic [NREQ-1:0]   gnt_nxt;
   logic [WIDTH-1:0]  q_nxt;
   logic              busy_nxt;
   logic              expired_nxt;
   logic [PW-1:0]     pick;
   logic              pick_valid;
   logic [WIDTH-1:0]  fv [NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_fv
      assign fv[g] = force_val[g*WIDTH +: WIDTH];
   end

   // Round-robin pick: first set request scanning upward from ptr, wrapping at NREQ.
   always_comb begin
      int            idx;
      logic [PW-1:0] idx_p;
      pick       = '0;
      pick_valid = 1'b0;
      idx        = 0;
      idx_p      = '0;
      for (int i = 0; i < NREQ; i++) begin
         idx = int'(ptr) + i;
         if (idx >= NREQ) idx = idx - NREQ;
         idx_p = PW'(idx);
         if (!pick_valid && req[idx_p]) begin
            pick       = idx_p;
            pick_valid = 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt   = state;
      ptr_nxt     = ptr;
      sel_nxt     = sel;
      cnt_nxt     = cnt;
      gnt_nxt     = gnt;
      q_nxt       = q;
      expired_nxt = 1'b0;
      case (state)
         IDLE: begin
            gnt_nxt = '0;
            if (pick_valid) begin
               state_nxt     = GRANT;
               gnt_nxt[pick] = 1'b1;
               q_nxt         = fv[pick];
               cnt_nxt       = CW'(1);
               sel_nxt       = pick;
               ptr_nxt       = (pick == PW'(NREQ - 1)) ? '0 : pick + PW'(1);
            end else begin
               q_nxt = din;
            end
         end
         GRANT: begin
            // A dropped request wins over a simultaneous timeout, so no expired pulse then.
            if (!req[sel]) begin
               state_nxt = RELEASE;
               gnt_nxt   = '0;
               q_nxt     = din;
            end else if (cnt == CW'(MAX_HOLD)) begin
               state_nxt   = RELEASE;
               gnt_nxt     = '0;
               q_nxt       = din;
               expired_nxt = 1'b1;
            end else begin
               q_nxt   = fv[sel];
               cnt_nxt = cnt + CW'(1);
            end
         end
         RELEASE: begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
            q_nxt     = din;
         end
         default: begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
         end
      endcase
      busy_nxt = (state_nxt != IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         ptr     <= '0;
         sel     <= '0;
         cnt     <= '0;
         gnt     <= '0;
         q       <= '0;
         busy    <= 1'b0;
         expired <= 1'b0;
      end else begin
         state   <= state_nxt;
         ptr     <= ptr_nxt;
         sel     <= sel_nxt;
         cnt     <= cnt_nxt;
         gnt     <= gnt_nxt;
         q       <= q_nxt;
         busy    <= busy_nxt;
         expired <= expired_nxt;
      end
   end

endmodule
